exe_mc_stage: RTL and testbench

Parametrised execute stage with an integrated EXE/MEM output register and valid/ready handshakes on both sides.
- Adds an iterative multiplier, MUL and MLA, alongside the single-cycle ALU ops. The multiplier is multi-cycle, so the stage must back-pressure decode.
- Sits between the ID/EXE register and the memory stage. Forwarding muxes on Rn/Rm and status generation are kept in the stage.

---
 rtl/exe_pkg.sv | 34 +++
 rtl/exe_iter_mul.sv | 90 +++++++++
 rtl/exe_mc_stage.sv | 211 +++++++++++++++++++++
 tb/tb_exe_mc_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage.
//   - CMD_*  : exe_cmd opcodes
//   - FWD_*  : forwarding-mux select codes
//   - mul_state_e : iterative multiplier FSM states
package exe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  localparam logic [1:0] FWD_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_MLA);
  endfunction

endpackage

// File: rtl/exe_iter_mul.sv
// Iterative multiply-accumulate, MUL_BPC multiplier bits per cycle.
//   start_i    : latch operands and begin (only honoured in ST_IDLE)
//   flush_i    : abandon any operation in flight
//   out_free_i : downstream output register can take a result this cycle
//   mcand_i, mplier_i, acc_i : operands; acc_i is the MLA addend (0 for MUL)
//   state_o    : FSM state (registered)
//   load_o     : result_o must be written to the output register this cycle
//   result_o   : low DATA_W bits of acc + mcand*mplier
module exe_iter_mul
  import exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_BPC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              out_free_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  input  logic [DATA_W-1:0] acc_i,
  output mul_state_e        state_o,
  output logic              load_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int N_STEPS = DATA_W / MUL_BPC;
  localparam int CNT_W   = $clog2(N_STEPS + 1);

  mul_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
  logic [DATA_W-1:0] pp_terms [MUL_BPC];
  logic [DATA_W-1:0] pp_sum, acc_step;
  logic              last_step;

  // mcand_q is pre-shifted each step, so each term only needs the local bit offset.
  for (genvar gi = 0; gi < MUL_BPC; gi++) begin : g_pp
    assign pp_terms[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < MUL_BPC; i++) pp_sum = pp_sum + pp_terms[i];
  end

  assign acc_step  = acc_q + pp_sum;
  assign last_step = (state_q == ST_MUL) && (cnt_q == CNT_W'(1));
  assign load_o    = out_free_i && (last_step || (state_q == ST_DONE));
  assign result_o  = (state_q == ST_DONE) ? acc_q : acc_step;
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            acc_q    <= acc_i;
            cnt_q    <= CNT_W'(N_STEPS);
            state_q  <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << MUL_BPC;
          mplier_q <= mplier_q >> MUL_BPC;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= out_free_i ? ST_IDLE : ST_DONE;
        end
        ST_DONE: begin
          if (out_free_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exe_mc_stage.sv
// Execute stage with forwarding muxes, single-cycle ALU, iterative MUL/MLA and
// an EXE/MEM output register, valid/ready on both sides.
//   in_valid/in_ready   : ID/EXE handshake; in_ready drops while multiplying
//   out_valid/out_ready : MEM handshake; outputs hold while stalled
//   flush               : drop in-flight multiply and output register contents
//   exe_cmd, controls, operands, forwarding selects : from ID/EXE
//   br_addr             : pc + sext(signed_imm), combinational
//   wb_en .. status     : registered EXE/MEM contents
module exe_mc_stage
  import exe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int MUL_BPC = 2,
  parameter int IMM_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [3:0]        exe_cmd,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              s_in,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val2,
  input  logic [DATA_W-1:0] val_ra,
  input  logic [IMM_W-1:0]  signed_imm,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              sr_c,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] wb_val,
  output logic [DATA_W-1:0] br_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              status_we,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_AW-1:0] dest,
  output logic [3:0]        status
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] src1, src2;
  logic              out_free, accept, alu_load, mul_start, mul_load;
  mul_state_e        mul_state;
  logic [DATA_W-1:0] mul_result;

  // ALU
  logic [DATA_W-1:0] alu_res, bb;
  logic [DATA_W:0]   sum;
  logic              cin, arith, alu_c, alu_v;

  // Controls captured at multiply accept, applied when the result lands.
  logic              m_wb_q, m_mr_q, m_mw_q, m_s_q, m_c_q;
  logic [REG_AW-1:0] m_dest_q;
  logic [DATA_W-1:0] m_st_q;

  // Output register
  logic              out_valid_q, wb_en_q, mem_r_en_q, mem_w_en_q, status_we_q;
  logic [DATA_W-1:0] alu_result_q, st_val_q;
  logic [REG_AW-1:0] dest_q;
  logic [3:0]        status_q;

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] reg_v,
                                               input logic [DATA_W-1:0] mem_v,
                                               input logic [DATA_W-1:0] wb_v);
    case (sel)
      FWD_REG: return reg_v;
      FWD_MEM: return mem_v;
      FWD_WB:  return wb_v;
      default: return '0;
    endcase
  endfunction

  assign src1    = fwd_mux(sel_src1, val_rn, mem_alu_result, wb_val);
  assign src2    = fwd_mux(sel_src2, val_rm, mem_alu_result, wb_val);
  assign br_addr = pc + {{(DATA_W-IMM_W){signed_imm[IMM_W-1]}}, signed_imm};

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = (mul_state == ST_IDLE) && out_free && !flush;
  assign accept    = in_valid && in_ready;
  assign alu_load  = accept && !is_mul_cmd(exe_cmd);
  assign mul_start = accept && is_mul_cmd(exe_cmd);

  // ALU second operand is always val2: shifted operands arrive already forwarded.
  // Subtraction is a + ~b + cin so the carry out is ARM's NOT-borrow.
  always_comb begin
    bb      = val2;
    cin     = 1'b0;
    arith   = 1'b0;
    alu_res = '0;
    alu_c   = sr_c;
    alu_v   = 1'b0;
    case (exe_cmd)
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin arith = 1'b1; cin = sr_c; end
      CMD_SUB: begin arith = 1'b1; bb = ~val2; cin = 1'b1; end
      CMD_SBC: begin arith = 1'b1; bb = ~val2; cin = sr_c; end
      default: ;
    endcase
    sum = {1'b0, src1} + {1'b0, bb} + {{DATA_W{1'b0}}, cin};
    case (exe_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_AND: alu_res = src1 & val2;
      CMD_ORR: alu_res = src1 | val2;
      CMD_EOR: alu_res = src1 ^ val2;
      default: ;
    endcase
    if (arith) begin
      alu_res = sum[DATA_W-1:0];
      alu_c   = sum[DATA_W];
      alu_v   = (src1[MSB] == bb[MSB]) && (alu_res[MSB] != src1[MSB]);
    end
  end

  exe_iter_mul #(.DATA_W(DATA_W), .MUL_BPC(MUL_BPC)) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start_i    (mul_start),
    .flush_i    (flush),
    .out_free_i (out_free),
    .mcand_i    (src1),
    .mplier_i   (src2),
    .acc_i      ((exe_cmd == CMD_MLA) ? val_ra : '0),
    .state_o    (mul_state),
    .load_o     (mul_load),
    .result_o   (mul_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wb_q   <= 1'b0;
      m_mr_q   <= 1'b0;
      m_mw_q   <= 1'b0;
      m_s_q    <= 1'b0;
      m_c_q    <= 1'b0;
      m_dest_q <= '0;
      m_st_q   <= '0;
    end else if (mul_start) begin
      m_wb_q   <= wb_en_in;
      m_mr_q   <= mem_r_en_in;
      m_mw_q   <= mem_w_en_in;
      m_s_q    <= s_in;
      m_c_q    <= sr_c;
      m_dest_q <= dest_in;
      m_st_q   <= src2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      status_we_q  <= 1'b0;
      alu_result_q <= '0;
      st_val_q     <= '0;
      dest_q       <= '0;
      status_q     <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (alu_load) begin
      out_valid_q  <= 1'b1;
      wb_en_q      <= wb_en_in;
      mem_r_en_q   <= mem_r_en_in;
      mem_w_en_q   <= mem_w_en_in;
      status_we_q  <= s_in;
      alu_result_q <= alu_res;
      st_val_q     <= src2;
      dest_q       <= dest_in;
      status_q     <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end else if (mul_load) begin
      out_valid_q  <= 1'b1;
      wb_en_q      <= m_wb_q;
      mem_r_en_q   <= m_mr_q;
      mem_w_en_q   <= m_mw_q;
      status_we_q  <= m_s_q;
      alu_result_q <= mul_result;
      st_val_q     <= m_st_q;
      dest_q       <= m_dest_q;
      status_q     <= {mul_result[MSB], (mul_result == '0), m_c_q, 1'b0};
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign wb_en      = wb_en_q;
  assign mem_r_en   = mem_r_en_q;
  assign mem_w_en   = mem_w_en_q;
  assign status_we  = status_we_q;
  assign alu_result = alu_result_q;
  assign st_val     = st_val_q;
  assign dest       = dest_q;
  assign status     = status_q;

endmodule

// File: tb/tb_exe_mc_stage.sv
module tb_exe_mc_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, flush;
  logic [3:0]  exe_cmd;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
  logic [31:0] pc, val_rn, val_rm, val2, val_ra;
  logic [23:0] signed_imm;
  logic [3:0]  dest_in;
  logic        sr_c;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_alu_result, wb_val, br_addr;
  logic        out_valid, out_ready;
  logic        wb_en, mem_r_en, mem_w_en, status_we;
  logic [31:0] alu_result, st_val;
  logic [3:0]  dest, status;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  exe_mc_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .exe_cmd(exe_cmd), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .s_in(s_in), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
    .val2(val2), .val_ra(val_ra), .signed_imm(signed_imm), .dest_in(dest_in),
    .sr_c(sr_c), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_alu_result(mem_alu_result), .wb_val(wb_val), .br_addr(br_addr),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .status_we(status_we), .alu_result(alu_result),
    .st_val(st_val), .dest(dest), .status(status)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] cmd, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [31:0] rn, input logic [31:0] rm, input logic [31:0] v2,
                       input logic c, input logic [3:0] d);
    in_valid = 1'b1; exe_cmd = cmd; sel_src1 = s1; sel_src2 = s2;
    val_rn = rn; val_rm = rm; val2 = v2; sr_c = c; dest_in = d;
    wb_en_in = 1'b1; s_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 0; flush = 0; exe_cmd = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    s_in = 0; pc = 32'h100; val_rn = 0; val_rm = 0; val2 = 0; val_ra = 0;
    signed_imm = 24'hFFFFFC; dest_in = 0; sr_c = 0; sel_src1 = 0; sel_src2 = 0;
    mem_alu_result = 32'd5; wb_val = 32'h55; out_ready = 1;
    #1 rst = 1'b0;
    #10;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (alu_result !== 32'h0) $display("FAIL reset_result got=%h exp=0", alu_result); else pass_cnt++;
    total_cnt++; if ({wb_en, mem_r_en, mem_w_en, status_we, status, dest} !== 12'h0)
      $display("FAIL reset_ctrl got=%h exp=0", {wb_en, mem_r_en, mem_w_en, status_we, status, dest}); else pass_cnt++;
    total_cnt++; if (br_addr !== 32'h000000FC) $display("FAIL br_addr_neg got=%h exp=000000fc", br_addr); else pass_cnt++;
    signed_imm = 24'h000010;
    #1;
    total_cnt++; if (br_addr !== 32'h00000110) $display("FAIL br_addr_pos got=%h exp=00000110", br_addr); else pass_cnt++;
    rst = 1'b1;
    tick;
  endtask

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  s1;
    logic [31:0] rn;
    logic [31:0] v2;
    logic        c;
    logic [31:0] res;
    logic [3:0]  st;
  } alu_vec_t;

  // mem_alu_result=5, wb_val=0x55; sel_src2=10 so st_val must be 0x55 while the
  // ALU keeps using val2. status = {N,Z,C,V}.
  alu_vec_t vecs [14] = '{
    '{CMD_ADD, 2'b00, 32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 4'b1001},
    '{CMD_SUB, 2'b01, 32'h9,        32'h5,        1'b0, 32'h0,        4'b0110},
    '{CMD_ADD, 2'b10, 32'h9,        32'h1,        1'b0, 32'h56,       4'b0000},
    '{CMD_ADD, 2'b11, 32'h9,        32'h7,        1'b0, 32'h7,        4'b0000},
    '{CMD_SUB, 2'b00, 32'h3,        32'h5,        1'b0, 32'hFFFFFFFE, 4'b1000},
    '{CMD_AND, 2'b00, 32'hF0F0,     32'hFF00,     1'b1, 32'hF000,     4'b0010},
    '{CMD_ORR, 2'b00, 32'hF0,       32'h0F,       1'b0, 32'hFF,       4'b0000},
    '{CMD_EOR, 2'b00, 32'hFF,       32'h0F,       1'b0, 32'hF0,       4'b0000},
    '{CMD_MVN, 2'b00, 32'h9,        32'h0,        1'b1, 32'hFFFFFFFF, 4'b1010},
    '{CMD_MOV, 2'b00, 32'h9,        32'h0,        1'b1, 32'h0,        4'b0110},
    '{CMD_ADC, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        4'b0110},
    '{CMD_SBC, 2'b00, 32'h5,        32'h3,        1'b0, 32'h1,        4'b0010},
    '{4'b1111, 2'b00, 32'h9,        32'h9,        1'b0, 32'h0,        4'b0100},
    '{CMD_ADD, 2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h0,        4'b0111}
  };

  task automatic test_back_to_back;
    out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].cmd, vecs[i].s1, 2'b10, vecs[i].rn, 32'h0, vecs[i].v2, vecs[i].c, 4'(i));
      tick;
      total_cnt++;
      if (out_valid !== 1'b1 || alu_result !== vecs[i].res || status !== vecs[i].st ||
          st_val !== 32'h55 || dest !== 4'(i) || status_we !== 1'b1)
        $display("FAIL alu_vec%0d got v=%b r=%h st=%b sv=%h d=%0d exp v=1 r=%h st=%b sv=00000055 d=%0d",
                 i, out_valid, alu_result, status, st_val, dest, vecs[i].res, vecs[i].st, i);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    out_ready = 0;
    drive(CMD_ADD, 2'b00, 2'b00, 32'h1, 32'h0, 32'h1, 1'b0, 4'd9);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    tick; tick;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_result !== 32'h0 || status !== 4'b0111 || dest !== 4'd13)
      $display("FAIL hold_outputs got v=%b r=%h st=%b d=%0d exp v=1 r=0 st=0111 d=13",
               out_valid, alu_result, status, dest);
    else pass_cnt++;
    in_valid = 0; out_ready = 1;
    tick;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL hold_drain got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_mla;
    int bad = 0;
    out_ready = 1; val_ra = 32'd10; mem_alu_result = 32'd7;
    drive(CMD_MLA, 2'b00, 2'b01, 32'd3, 32'd100, 32'd0, 1'b0, 4'd5);
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mla_accept got=%b exp=1", in_ready); else pass_cnt++;
    tick;
    in_valid = 0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL mla_busy got=%0d bad cycles exp=0", bad); else pass_cnt++;
    tick;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_result !== 32'd31 || status !== 4'b0000 || dest !== 4'd5 ||
        st_val !== 32'd7 || wb_en !== 1'b1)
      $display("FAIL mla_result got v=%b r=%h st=%b d=%0d sv=%h exp v=1 r=0000001f st=0000 d=5 sv=00000007",
               out_valid, alu_result, status, dest, st_val);
    else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL mla_ready_after got=%b exp=1", in_ready); else pass_cnt++;
    drive(CMD_ADD, 2'b00, 2'b00, 32'd1, 32'd0, 32'd2, 1'b0, 4'd6);
    tick;
    in_valid = 0;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_result !== 32'd3 || dest !== 4'd6)
      $display("FAIL mla_next got v=%b r=%h d=%0d exp v=1 r=00000003 d=6", out_valid, alu_result, dest);
    else pass_cnt++;
    mem_alu_result = 32'd5;
  endtask

  // The output register is empty while a multiply runs, so a stalled consumer
  // only blocks once the result is presented; it must then hold.
  task automatic test_stall;
    out_ready = 1;
    drive(CMD_MUL, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b1, 4'd7);
    tick;
    in_valid = 0; out_ready = 0; sr_c = 0;
    repeat (15) tick;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_early got=%b exp=0", out_valid); else pass_cnt++;
    tick;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_result !== 32'hFFFFFFFE || status !== 4'b1010 || dest !== 4'd7)
      $display("FAIL stall_result got v=%b r=%h st=%b d=%0d exp v=1 r=fffffffe st=1010 d=7",
               out_valid, alu_result, status, dest);
    else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    tick; tick;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_result !== 32'hFFFFFFFE || st_val !== 32'd2)
      $display("FAIL stall_hold got v=%b r=%h sv=%h exp v=1 r=fffffffe sv=00000002", out_valid, alu_result, st_val);
    else pass_cnt++;
    out_ready = 1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_release got=%b exp=1", in_ready); else pass_cnt++;
    tick;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_drain got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_flush;
    int stale = 0;
    out_ready = 1;
    drive(CMD_MUL, 2'b00, 2'b00, 32'd5, 32'd5, 32'd0, 1'b0, 4'd8);
    tick;
    in_valid = 0;
    repeat (4) tick;
    flush = 1;
    drive(CMD_ADD, 2'b00, 2'b00, 32'd4, 32'd0, 32'd4, 1'b0, 4'd9);
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_blocks got=%b exp=0", in_ready); else pass_cnt++;
    tick;
    flush = 0; in_valid = 0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_after got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (out_valid !== 1'b0) stale++;
    end
    total_cnt++; if (stale != 0) $display("FAIL flush_stale got=%0d exp=0", stale); else pass_cnt++;
  endtask

  task automatic test_async_reset;
    int stale = 0;
    out_ready = 1;
    drive(CMD_MUL, 2'b00, 2'b00, 32'd3, 32'd3, 32'd0, 1'b0, 4'd4);
    tick;
    in_valid = 0;
    repeat (3) tick;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || alu_result !== 32'h0 || st_val !== 32'h0 || status !== 4'h0 ||
        dest !== 4'h0 || wb_en !== 1'b0 || status_we !== 1'b0)
      $display("FAIL async_reset got v=%b r=%h sv=%h st=%b d=%0d exp all 0",
               out_valid, alu_result, st_val, status, dest);
    else pass_cnt++;
    #3 rst = 1'b1;
    tick;
    drive(CMD_ADD, 2'b00, 2'b00, 32'd1, 32'd0, 32'd1, 1'b0, 4'd2);
    tick;
    in_valid = 0;
    total_cnt++;
    if (out_valid !== 1'b1 || alu_result !== 32'd2 || dest !== 4'd2)
      $display("FAIL reset_add got v=%b r=%h d=%0d exp v=1 r=00000002 d=2", out_valid, alu_result, dest);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid !== 1'b0) stale++;
    end
    total_cnt++; if (stale != 0) $display("FAIL reset_discard got=%0d exp=0", stale); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_hold;
    test_mla;
    test_stall;
    test_flush;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
